mul_sequencer: RTL
==================

Name: mul_sequencer

Overview:
Multi-cycle execute-stage controller that runs the `mul` ALU operation (ALUCtrl = 3'b011) as an iterative radix-2 shift-add over WIDTH cycles. It holds the EX stage, and everything upstream of it, with a Stall output while the multiply runs. On completion it presents the low WIDTH bits of the product for one Done cycle, which the EX result mux selects in place of the single-cycle ALU output. Sits beside the ALU in EX and is driven by the same ALUCtrl and operand buses.

Parameters:
WIDTH, 32, operand and result width; also the iteration count.
CNT_W, 6, counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
Clk  in  1  clock; all state updates on rising edge.
Rst  in  1  synchronous, active-high reset.
Valid  in  1  EX stage holds a live instruction.
ALUCtrl  in  3  ALU control code from ALUControl; 3'b011 = mul.
Flush  in  1  EX instruction squashed (branch/jump); aborts any multiply.
OperandA  in  WIDTH  multiplicand (rs after forwarding).
OperandB  in  WIDTH  multiplier (rt after forwarding).
Stall  out  1  combinational; holds PC, IF/ID, ID/EX and EX inputs.
Done  out  1  registered state decode; Result valid this cycle.
Busy  out  1  registered; state == RUN.
Result  out  WIDTH  registered low WIDTH bits of OperandA*OperandB.

Behaviour:
- Start = Valid & (ALUCtrl == 3'b011) & ~Flush.
- States: IDLE, RUN, DONE.
  - IDLE: Start -> RUN. Latch mcand = OperandA, mplier = OperandB, acc = 0, cnt = 0. Otherwise stay.
  - RUN: each cycle, if mplier[0] then acc <= acc + mcand (mod 2**WIDTH). Then mcand <= mcand << 1, mplier <= mplier >> 1 (logical), cnt <= cnt + 1. When cnt == WIDTH-1, go to DONE and Result <= final acc (including that cycle's add).
  - DONE: Done = 1 for exactly one cycle, then unconditionally -> IDLE. Start is ignored in DONE; it belongs to the retiring instruction.
- Stall = ~Flush & ((state == IDLE & Start) | state == RUN). Stall is 0 in DONE so the pipeline advances with Result.
- Latency: Start seen in IDLE at cycle 0. RUN occupies cycles 1..WIDTH. DONE is at cycle WIDTH+1. Stall is high for cycles 0..WIDTH (WIDTH+1 cycles).
- Result holds its value until the next DONE. Only the low product bits are kept, which are identical for signed and unsigned operands. No overflow flag.
- Operands are sampled only on the IDLE->RUN transition; later changes to OperandA/B are ignored.
- Flush in RUN: next state IDLE, no Done, Result unchanged; Stall drops in the same cycle. Flush in IDLE: suppresses Start. Flush in DONE: no effect; it goes to IDLE anyway.
- Back-to-back mul: the second instruction enters EX the cycle after DONE, is seen in IDLE, and starts a fresh sequence. There is no bubble beyond the DONE cycle.
- A non-mul ALUCtrl, or Valid = 0, never asserts Stall or Done.
- Rst (synchronous): state = IDLE; mcand, mplier, acc, cnt, Result = 0; Done = 0, Busy = 0, Stall = 0. Rst mid-RUN abandons the operation. Rst has priority over Flush and Start.

Decomposition:
- Shared package mips_alu_pkg:
  - ALU control codes ALU_ADD 3'b000, ALU_SUB 3'b001, ALU_SLT 3'b010, ALU_MUL 3'b011, ALU_SLL 3'b100.
  - State encodings S_IDLE 2'b00, S_RUN 2'b01, S_DONE 2'b10.
  - ALUControl is migrated to the same code constants.
- One natural sub-module, mul_seq_datapath: mcand/mplier/acc registers, adder, shifters, with load/step controls. The FSM, counter and Stall logic stay in mul_sequencer.

Test Plan (WIDTH = 32):
- Basic: Valid = 1, ALUCtrl = 011, A = 6, B = 7 -> Stall high cycles 0..32, Done at cycle 33, Result = 42.
- Signed and overflow: A = 0xFFFFFFFD (-3), B = 5 -> Result = 0xFFFFFFF1. A = 0x00010000, B = 0x00010000 -> Result = 0x00000000.
- Non-mul: ALUCtrl = 000 and 010 with Valid = 1, and ALUCtrl = 011 with Valid = 0 -> Stall, Done and Busy stay 0; Result unchanged.
- Flush at cycle 10 of a 6*7 run -> Stall low in cycle 10, state IDLE at 11, Done never asserts, Result keeps its prior value. A following 2*3 -> Result = 6.
- Rst at cycle 5 of a run -> next cycle all outputs 0, state IDLE. Operands changed mid-run (without Rst) do not alter Result.
- Back-to-back: 0x12345678*3, then 0xFFFFFFFF*0xFFFFFFFF -> Done pulses at cycles 33 and 67, Results 0x369D0368 and 0x00000001.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared ALU control codes and multiply-sequencer state encodings for the EX stage.
package mips_alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_seq_datapath.sv
// Radix-2 shift-add datapath: multiplicand/multiplier/accumulator registers and result capture.
module mul_seq_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             capture,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] acc_sum;

  // Sum includes the current cycle's partial product so the final capture needs no extra cycle.
  assign acc_sum = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (load) begin
      mcand_d  = op_a;
      mplier_d = op_b;
      acc_d    = '0;
    end else if (step) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_sum;
    end
    if (capture) begin
      result_d = acc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/mul_sequencer.sv
// EX-stage multi-cycle mul controller: FSM, iteration counter and pipeline stall generation.
//   state  | meaning
//   S_IDLE | waiting for a mul; Start loads operands
//   S_RUN  | one shift-add step per cycle, WIDTH steps
//   S_DONE | Result valid for one cycle, pipeline advances
module mul_sequencer
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Valid,
  input  logic [2:0]       ALUCtrl,
  input  logic             Flush,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Stall,
  output logic             Done,
  output logic             Busy,
  output logic [WIDTH-1:0] Result
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start;
  logic             load, step, capture;

  assign start = Valid & (ALUCtrl == ALU_MUL) & ~Flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
            capture = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mul_seq_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (Clk),
    .rst     (Rst),
    .load    (load),
    .step    (step),
    .capture (capture),
    .op_a    (OperandA),
    .op_b    (OperandB),
    .result  (Result)
  );

  assign Stall = ~Flush & (((state_q == S_IDLE) & start) | (state_q == S_RUN));
  assign Done  = (state_q == S_DONE);
  assign Busy  = (state_q == S_RUN);

endmodule
